// File: rtl/uart_core_param.sv
// Parametrised fabric UART: TX serialiser, RX deserialiser with 2-FF synchroniser,
// mid-bit sampling, start-glitch rejection, error pulses and a first-word-fall-through RX FIFO.
module uart_core_param #(
  parameter int CLK_FREQ      = 40_000_000,
  parameter int BAUD          = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 uart_rxd_i,
  output logic                 uart_txd_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_overflow_o
);
  localparam int DIV = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF  = CW'(DIV/2 - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(RX_FIFO_DEPTH);
  localparam bit PEN  = (PARITY != 0);
  localparam bit PODD = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

  // ---------------- TX ----------------
  st_t                  tx_st, tx_st_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n, txd_n, tx_tick;

  assign tx_tick   = (tx_cnt == LAST);
  assign tx_busy_o = ~tx_ready_o;

  always_comb begin
    tx_st_n    = tx_st;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    txd_n      = uart_txd_o;
    tx_ready_o = 1'b0;
    case (tx_st)
      S_IDLE: begin
        tx_ready_o = 1'b1;
        tx_cnt_n   = '0;
        txd_n      = 1'b1;
      end
      S_START: if (tx_tick) begin
        tx_st_n  = S_DATA;
        tx_cnt_n = '0;
        tx_bit_n = '0;
        txd_n    = tx_sh[0];
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_n = '0;
        if (tx_bit == DLAST) begin
          tx_bit_n = '0;
          if (PEN) begin
            tx_st_n = S_PAR;
            txd_n   = tx_par;
          end else begin
            tx_st_n = S_STOP;
            txd_n   = 1'b1;
          end
        end else begin
          tx_bit_n = tx_bit + 4'(1);
          tx_sh_n  = tx_sh >> 1;
          txd_n    = tx_sh[1];
        end
      end
      S_PAR: if (tx_tick) begin
        tx_st_n  = S_STOP;
        tx_cnt_n = '0;
        tx_bit_n = '0;
        txd_n    = 1'b1;
      end
      S_STOP: if (tx_tick) begin
        tx_cnt_n = '0;
        if (tx_bit == SLAST) begin
          tx_ready_o = 1'b1;
          tx_st_n    = S_IDLE;
          txd_n      = 1'b1;
        end else begin
          tx_bit_n = tx_bit + 4'(1);
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
    // Accept in idle or in the last stop cycle; the latter gives back-to-back frames.
    if (tx_ready_o && tx_valid_i) begin
      tx_st_n  = S_START;
      tx_cnt_n = '0;
      txd_n    = 1'b0;
      tx_sh_n  = tx_data_i;
      tx_par_n = (^tx_data_i) ^ PODD;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_st      <= S_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_par     <= 1'b0;
      uart_txd_o <= 1'b1;
    end else begin
      tx_st      <= tx_st_n;
      tx_cnt     <= tx_cnt_n;
      tx_bit     <= tx_bit_n;
      tx_sh      <= tx_sh_n;
      tx_par     <= tx_par_n;
      uart_txd_o <= txd_n;
    end
  end

  // ---------------- RX ----------------
  logic [1:0]           sync;
  logic                 rxs, rxs_d, rx_tick;
  st_t                  rx_st, rx_st_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n, push_d;
  logic                 rx_par, rx_par_n, push_n, perr_n, ferr_n, push_q;

  assign rxs     = sync[1];
  assign rx_tick = (rx_cnt == LAST);

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + CW'(1);
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_par_n = rx_par;
    push_n   = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    case (rx_st)
      // Edge-triggered start: a line held low after a break never restarts a frame.
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rxs_d && !rxs) rx_st_n = S_START;
      end
      S_START: if (rx_cnt == HALF) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n  = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rxs, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == DLAST) rx_st_n = PEN ? S_PAR : S_STOP;
        else                 rx_bit_n = rx_bit + 4'(1);
      end
      S_PAR: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_par_n = rxs;
        rx_st_n  = S_STOP;
      end
      S_STOP: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_st_n  = S_IDLE;
        if (!rxs)                                      ferr_n = 1'b1;
        else if (PEN && ((^rx_sh) ^ rx_par ^ PODD))    perr_n = 1'b1;
        else                                           push_n = 1'b1;
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync            <= 2'b11;
      rxs_d           <= 1'b1;
      rx_st           <= S_IDLE;
      rx_cnt          <= '0;
      rx_bit          <= '0;
      rx_sh           <= '0;
      rx_par          <= 1'b0;
      push_q          <= 1'b0;
      push_d          <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
    end else begin
      sync            <= {sync[0], uart_rxd_i};
      rxs_d           <= rxs;
      rx_st           <= rx_st_n;
      rx_cnt          <= rx_cnt_n;
      rx_bit          <= rx_bit_n;
      rx_sh           <= rx_sh_n;
      rx_par          <= rx_par_n;
      push_q          <= push_n;
      push_d          <= rx_sh;
      rx_parity_err_o <= perr_n;
      rx_frame_err_o  <= ferr_n;
    end
  end

  // ---------------- RX FIFO (first-word-fall-through) ----------------
  logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [AW:0]          fcnt;
  logic                 pop, full, wr;

  assign rx_valid_o = (fcnt != '0);
  assign rx_data_o  = mem[rp];
  assign pop        = rx_valid_o & rx_ready_i;
  assign full       = (fcnt == FULL);
  assign wr         = push_q & (~full | pop);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
      wp            <= '0;
      rp            <= '0;
      fcnt          <= '0;
      rx_overflow_o <= 1'b0;
    end else begin
      rx_overflow_o <= push_q & full & ~pop;
      if (wr) begin
        mem[wp] <= push_d;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      case ({wr, pop})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: two instances (8N1 depth 4, 8E2 depth 16), queue scoreboard
// with decoupled monitors, bench-built serial frames and a TX loopback.
module tb_uart_core_param;
  localparam int DIV = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: 8N1, depth 4
  logic       rxd0 = 1'b1, txd0, txv0 = 1'b0, rdy0, busy0, rxv0, rxr0 = 1'b1, pe0, fe0, ov0;
  logic [7:0] txdat0 = '0, rxdat0;
  // instance 1: 8E2, depth 16, RX fed from own TX and a bench driver
  logic       rxd1, rxd1_drv = 1'b1, txd1, txv1 = 1'b0, rdy1, busy1, rxv1, rxr1 = 1'b1, pe1, fe1, ov1;
  logic [7:0] txdat1 = '0, rxdat1;
  assign rxd1 = txd1 & rxd1_drv;

  uart_core_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u0 (
    .clk_i(clk), .reset_n_i(rst_n), .uart_rxd_i(rxd0), .uart_txd_o(txd0),
    .tx_data_i(txdat0), .tx_valid_i(txv0), .tx_ready_o(rdy0), .tx_busy_o(busy0),
    .rx_data_o(rxdat0), .rx_valid_o(rxv0), .rx_ready_i(rxr0),
    .rx_parity_err_o(pe0), .rx_frame_err_o(fe0), .rx_overflow_o(ov0));

  uart_core_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .RX_FIFO_DEPTH(16)) u1 (
    .clk_i(clk), .reset_n_i(rst_n), .uart_rxd_i(rxd1), .uart_txd_o(txd1),
    .tx_data_i(txdat1), .tx_valid_i(txv1), .tx_ready_o(rdy1), .tx_busy_o(busy1),
    .rx_data_o(rxdat1), .rx_valid_o(rxv1), .rx_ready_i(rxr1),
    .rx_parity_err_o(pe1), .rx_frame_err_o(fe1), .rx_overflow_o(ov1));

  int chk = 0, err = 0;
  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard queues and event counters
  logic [7:0] q0[$], q1[$];
  int pe_c0 = 0, fe_c0 = 0, ov_c0 = 0, pe_c1 = 0, fe_c1 = 0, ov_c1 = 0;
  int exp_fe0 = 0, exp_ov0 = 0, exp_pe1 = 0;

  always @(negedge clk) if (rst_n) begin
    if (rxv0 && rxr0) begin
      if (q0.size() == 0) begin
        chk++; err++;
        $display("FAIL rx0_unexpected actual=%0h required=none", rxdat0);
      end else check("rx0_data", int'(rxdat0), int'(q0.pop_front()));
    end
    if (rxv1 && rxr1) begin
      if (q1.size() == 0) begin
        chk++; err++;
        $display("FAIL rx1_unexpected actual=%0h required=none", rxdat1);
      end else check("rx1_data", int'(rxdat1), int'(q1.pop_front()));
    end
    pe_c0 += int'(pe0); fe_c0 += int'(fe0); ov_c0 += int'(ov0);
    pe_c1 += int'(pe1); fe_c1 += int'(fe1); ov_c1 += int'(ov1);
  end

  // serial frame drivers, LSB first, bit period DIV cycles
  task automatic send0(input logic [7:0] d, input logic stop);
    logic [9:0] b;
    b = {stop, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd0 = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (stop) begin
      rxd0 = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic flip);
    logic [11:0] b;
    b = {2'b11, (^d) ^ flip, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rxd1_drv = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd1_drv = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // model of a depth-4 receiver: a good word is kept unless 4 are already unread
  task automatic good0(input logic [7:0] d);
    if (rxr0 == 1'b0 && q0.size() >= 4) exp_ov0++;
    else q0.push_back(d);
    send0(d, 1'b1);
  endtask

  task automatic drain(input string name);
    int to;
    to = 0;
    while ((q0.size() != 0 || q1.size() != 0) && to < 3000) begin
      @(posedge clk); to++;
    end
    check(name, q0.size() + q1.size(), 0);
  endtask

  initial begin
    logic [9:0] f;
    logic [7:0] w;
    int to, hs, last_hs;

    // reset held
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd0", txd0, 1);   check("rst_ready0", rdy0, 1);  check("rst_busy0", busy0, 0);
    check("rst_rxv0", rxv0, 0);   check("rst_rxdat0", rxdat0, 0);
    check("rst_err0", {pe0, fe0, ov0}, 0);
    check("rst_txd1", txd1, 1);   check("rst_ready1", rdy1, 1);  check("rst_rxv1", rxv1, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // TX 8N1 0xA5: exact frame timing and ready return
    f = {1'b1, 8'hA5, 1'b0};
    txdat0 = 8'hA5; txv0 = 1'b1;
    @(posedge clk); #1; txv0 = 1'b0; txdat0 = $urandom;
    for (int c = 1; c <= 160; c++) begin
      check($sformatf("tx_bit_c%0d", c), txd0, f[(c-1)/DIV]);
      check("tx_ready", rdy0, int'(c == 160));
      check("tx_busy", busy0, int'(c != 160));
      if (c < 160) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("tx_idle_txd", txd0, 1);

    // reset mid-frame
    @(negedge clk); txdat0 = 8'h00; txv0 = 1'b1;
    @(posedge clk); #1; txv0 = 1'b0;
    repeat (50) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midrst_txd", txd0, 1); check("midrst_ready", rdy0, 1);
    check("midrst_busy", busy0, 0); check("midrst_rxv", rxv0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_txd", txd0, 1); check("postrst_ready", rdy0, 1);

    // RX 8N1 random words, consumer ready
    for (int i = 0; i < 4; i++) good0(8'($urandom));
    drain("rx0_drain");

    // start glitch: 5 low cycles, then a good word proves the FSM is idle
    @(negedge clk); rxd0 = 1'b0;
    repeat (5) @(negedge clk);
    rxd0 = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_rxv", rxv0, 0);
    check("glitch_flags", fe_c0 + pe_c0 + ov_c0, 0);
    good0(8'h96);
    drain("glitch_drain");

    // frame error with a long break: exactly one pulse, no word
    send0(8'h55, 1'b0); exp_fe0++;
    repeat (200) @(negedge clk);
    check("brk_rxv", rxv0, 0);
    rxd0 = 1'b1;
    repeat (30) @(negedge clk);
    check("frame_err_cnt", fe_c0, exp_fe0);
    good0(8'hC3);
    drain("brk_drain");

    // overflow: 5 words into depth 4 with no consumer
    @(posedge clk); #1; rxr0 = 1'b0;
    for (int i = 1; i <= 5; i++) good0(8'(i));
    check("ovf_rxv", rxv0, 1);
    check("ovf_cnt", ov_c0, exp_ov0);
    check("ovf_exp", exp_ov0, 1);
    check("ovf_q", q0.size(), 4);
    @(posedge clk); #1; rxr0 = 1'b1;
    drain("ovf_drain");

    // parity: flipped parity dropped, correct one kept
    send1(8'h3C, 1'b1); exp_pe1++;
    check("par_rxv", rxv1, 0);
    check("par_cnt", pe_c1, exp_pe1);
    q1.push_back(8'h3C);
    send1(8'h3C, 1'b0);
    drain("par_drain");

    // loopback 8E2, 32 random words back-to-back
    last_hs = 0;
    for (int k = 0; k < 32; k++) begin
      w = 8'($urandom);
      @(negedge clk); txdat1 = w; txv1 = 1'b1;
      to = 0;
      while (!rdy1 && to < 400) begin @(negedge clk); to++; end
      check("lb_ready_timeout", int'(to >= 400), 0);
      hs = cyc + 1;
      q1.push_back(w);
      if (k > 0) check("lb_gap", hs - last_hs, 12 * DIV);
      last_hs = hs;
      @(posedge clk); #1;
    end
    txv1 = 1'b0;
    repeat (12 * DIV + 40) @(posedge clk);
    drain("lb_drain");

    check("end_pe0", pe_c0, 0);      check("end_fe0", fe_c0, exp_fe0);
    check("end_ov0", ov_c0, exp_ov0); check("end_pe1", pe_c1, exp_pe1);
    check("end_fe1", fe_c1, 0);      check("end_ov1", ov_c1, 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
